reg_bus_arbiter: RTL and testbench



---
 rtl/reg_bus_arbiter_if.sv | 35 +++
 rtl/reg_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_arbiter_if.sv
// Request/grant and RegIO bus bundle for reg_bus_arbiter.
// slave = arbiter side, master = client/RegIO side.
interface reg_bus_arbiter_if #(
  parameter int NCLIENT = 4,
  parameter int OFFW    = 8,
  parameter int DATAW   = 16
);
  localparam int IDW = $clog2(NCLIENT);

  logic [NCLIENT-1:0]       req_i;
  logic [NCLIENT*OFFW-1:0]  cli_offset_i;
  logic [NCLIENT-1:0]       cli_length_i;
  logic [NCLIENT-1:0]       cli_wr_i;
  logic [NCLIENT*DATAW-1:0] cli_wdata_i;
  logic [NCLIENT-1:0]       cli_newcmd_i;
  logic                     io_busy_i;
  logic [NCLIENT-1:0]       gnt_o;
  logic [IDW-1:0]           grant_id_o;
  logic [OFFW-1:0]          offset_o;
  logic                     length_o;
  logic                     WR_o;
  logic [DATAW-1:0]         writeData_o;
  logic                     NewCommand_o;
  logic                     err_o;

  modport slave (
    input  req_i, cli_offset_i, cli_length_i, cli_wr_i, cli_wdata_i, cli_newcmd_i, io_busy_i,
    output gnt_o, grant_id_o, offset_o, length_o, WR_o, writeData_o, NewCommand_o, err_o
  );

  modport master (
    output req_i, cli_offset_i, cli_length_i, cli_wr_i, cli_wdata_i, cli_newcmd_i, io_busy_i,
    input  gnt_o, grant_id_o, offset_o, length_o, WR_o, writeData_o, NewCommand_o, err_o
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Shares the RegIO register port between NCLIENT clients: request/grant, burst ownership, busy watchdog.
// Define REG_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module reg_bus_arbiter #(
  parameter int NCLIENT = 4,
  parameter int OFFW    = 8,
  parameter int DATAW   = 16,
  parameter int TIMEOUT = 1023
) (
  input logic              clk40m,
  input logic              RSTN,
  reg_bus_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NCLIENT);
  localparam logic [15:0] TIMEOUT16 = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [NCLIENT-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic               err_q, err_d;
  logic [15:0]        wdog_q, wdog_d;
  logic [15:0]        wdogInc;
  logic [IDW-1:0]     win;
  logic               busyCount;
  logic               fault;
  logic               ownerReq;
`ifdef REG_ARB_RR_EN
  logic [IDW-1:0]     rr_q, rr_d;
  logic               found;
  int                 idx;
`endif

`ifdef REG_ARB_RR_EN
  // Search begins one past the last granted client, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NCLIENT; k++) begin
      idx = (int'(rr_q) + k) % NCLIENT;
      if (!found && bus.req_i[IDW'(idx)]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NCLIENT - 1; i >= 0; i--) begin
      if (bus.req_i[i]) win = IDW'(i);
    end
  end
`endif

  assign ownerReq  = |(bus.req_i & gnt_q);
  assign busyCount = (state_q != IDLE) && bus.io_busy_i;
  assign wdogInc   = wdog_q + 16'd1;
  assign fault     = busyCount && (wdogInc == TIMEOUT16);

  always_ff @(posedge clk40m or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gid_q   <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
`ifdef REG_ARB_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
`ifdef REG_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    err_d   = err_q;
    wdog_d  = busyCount ? wdogInc : 16'd0;
`ifdef REG_ARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          state_d = OWN;
          gnt_d   = NCLIENT'(1) << win;
          gid_d   = win;
`ifdef REG_ARB_RR_EN
          rr_d    = win;
`endif
        end
      end
      OWN, DRAIN: begin
        // A watchdog fault revokes ownership even while the owner still requests.
        if (fault) begin
          state_d = IDLE;
          gnt_d   = '0;
          gid_d   = '0;
          err_d   = 1'b1;
          wdog_d  = '0;
        end else if (state_q == OWN && !ownerReq) begin
          if (bus.io_busy_i) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            gid_d   = '0;
          end
        end else if (state_q == DRAIN && !bus.io_busy_i) begin
          state_d = IDLE;
          gnt_d   = '0;
          gid_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.offset_o     = '0;
    bus.length_o     = 1'b1;
    bus.WR_o         = 1'b0;
    bus.writeData_o  = '0;
    bus.NewCommand_o = 1'b0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (gnt_q[i]) begin
        bus.offset_o     = bus.cli_offset_i[i*OFFW +: OFFW];
        bus.length_o     = bus.cli_length_i[i];
        bus.WR_o         = bus.cli_wr_i[i];
        bus.writeData_o  = bus.cli_wdata_i[i*DATAW +: DATAW];
        bus.NewCommand_o = (state_q == OWN) && bus.cli_newcmd_i[i];
      end
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.grant_id_o = gid_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed steps then randomized traffic
// against a transaction-level reference model (follows REG_ARB_RR_EN if defined).
module tb_reg_bus_arbiter;
  localparam int NC = 4;
  localparam int OW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic clk40m = 1'b0;
  logic RSTN   = 1'b0;
  always #5 clk40m = ~clk40m;

  reg_bus_arbiter_if #(.NCLIENT(NC), .OFFW(OW), .DATAW(DW)) bus ();

  reg_bus_arbiter #(.NCLIENT(NC), .OFFW(OW), .DATAW(DW), .TIMEOUT(TO)) dut (
    .clk40m (clk40m),
    .RSTN   (RSTN),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: current owner (-1 none), draining flag, busy run length, sticky error, last grant.
  int mOwner;
  int mDrain;
  int mCnt;
  int mErr;
  int mPtr;

  task automatic modelReset();
    mOwner = -1;
    mDrain = 0;
    mCnt   = 0;
    mErr   = 0;
    mPtr   = 0;
  endtask

  task automatic modelEdge();
    logic [3:0] r;
    logic       b;
    r = bus.req_i;
    b = bus.io_busy_i;
    if (mOwner < 0) begin
      if (r != 4'd0) begin
`ifdef REG_ARB_RR_EN
        for (int k = 1; k <= NC; k++) begin
          int c;
          c = (mPtr + k) % NC;
          if (mOwner < 0 && r[2'(c)]) mOwner = c;
        end
`else
        for (int c = 0; c < NC; c++) begin
          if (mOwner < 0 && r[2'(c)]) mOwner = c;
        end
`endif
        mPtr   = mOwner;
        mCnt   = 0;
        mDrain = 0;
      end
    end else begin
      mCnt = b ? mCnt + 1 : 0;
      if (b && mCnt == TO) begin
        mErr   = 1;
        mOwner = -1;
        mCnt   = 0;
        mDrain = 0;
      end else if (mDrain == 0) begin
        if (!r[2'(mOwner)]) begin
          if (b) mDrain = 1;
          else mOwner = -1;
        end
      end else if (!b) begin
        mOwner = -1;
        mDrain = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [3:0]  eg;
    logic [1:0]  ei;
    logic [7:0]  eo;
    logic        el;
    logic        ew;
    logic [15:0] ed;
    logic        en;
    if (mOwner >= 0) begin
      eg = 4'(1 << mOwner);
      ei = 2'(mOwner);
      eo = 8'(bus.cli_offset_i >> (mOwner * OW));
      el = bus.cli_length_i[2'(mOwner)];
      ew = bus.cli_wr_i[2'(mOwner)];
      ed = 16'(bus.cli_wdata_i >> (mOwner * DW));
      en = (mDrain == 0) && bus.cli_newcmd_i[2'(mOwner)];
    end else begin
      eg = 4'd0;
      ei = 2'd0;
      eo = 8'd0;
      el = 1'b1;
      ew = 1'b0;
      ed = 16'd0;
      en = 1'b0;
    end
    checkOutput({tag, ".gnt"},       32'(bus.gnt_o),        32'(eg));
    checkOutput({tag, ".grant_id"},  32'(bus.grant_id_o),   32'(ei));
    checkOutput({tag, ".offset"},    32'(bus.offset_o),     32'(eo));
    checkOutput({tag, ".length"},    32'(bus.length_o),     32'(el));
    checkOutput({tag, ".WR"},        32'(bus.WR_o),         32'(ew));
    checkOutput({tag, ".writeData"}, 32'(bus.writeData_o),  32'(ed));
    checkOutput({tag, ".NewCmd"},    32'(bus.NewCommand_o), 32'(en));
    checkOutput({tag, ".err"},       32'(bus.err_o),        32'(mErr));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] nc, input logic b);
    bus.req_i        = r;
    bus.cli_newcmd_i = nc;
    bus.io_busy_i    = b;
    #1;
  endtask

  task automatic edgeOnly();
    @(posedge clk40m);
    modelEdge();
    #1;
  endtask

  task automatic cycle(input string tag);
    checkAll(tag);
    edgeOnly();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    logic [3:0] rq;
    logic       bsy;
    int         longBusy;
    logic [3:0] expRr;
    logic [3:0] expRst;

`ifdef REG_ARB_RR_EN
    expRr  = 4'b1000;
    expRst = 4'b0010;
`else
    expRr  = 4'b0010;
    expRst = 4'b0001;
`endif

    modelReset();
    bus.req_i        = 4'd0;
    bus.cli_newcmd_i = 4'd0;
    bus.io_busy_i    = 1'b0;
    bus.cli_offset_i = 32'h1312_111C;
    bus.cli_length_i = 4'b0101;
    bus.cli_wr_i     = 4'b1010;
    bus.cli_wdata_i  = 64'hD003_D002_D001_D000;
    #3;
    checkAll("rst");
    checkOutput("rst.length1", 32'(bus.length_o), 32'd1);
    @(negedge clk40m);
    RSTN = 1'b1;
    edgeOnly();

    // Single client grant and same-cycle command forwarding
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("t1.idle_gnt", 32'(bus.gnt_o), 32'd0);
    cycle("t1a");
    checkOutput("t1.gnt", 32'(bus.gnt_o), 32'b0001);
    checkOutput("t1.id", 32'(bus.grant_id_o), 32'd0);
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    checkOutput("t1.offset", 32'(bus.offset_o), 32'h1C);
    checkOutput("t1.newcmd", 32'(bus.NewCommand_o), 32'd1);
    cycle("t1b");
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    cycle("t1c");
    checkOutput("t1.release", 32'(bus.gnt_o), 32'd0);

    // Simultaneous requests, non-owner strobe, dead cycle, RR rotation
    applyStimulus(4'b1010, 4'b0000, 1'b0);
    cycle("t2a");
    checkOutput("t2.gnt", 32'(bus.gnt_o), 32'b0010);
    checkOutput("t2.id", 32'(bus.grant_id_o), 32'd1);
    applyStimulus(4'b1010, 4'b1000, 1'b0);
    checkOutput("t2.nonowner_cmd", 32'(bus.NewCommand_o), 32'd0);
    checkOutput("t2.offset", 32'(bus.offset_o), 32'h11);
    cycle("t2b");
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    cycle("t2c");
    checkOutput("t2.dead", 32'(bus.gnt_o), 32'd0);
    applyStimulus(4'b1010, 4'b0000, 1'b0);
    cycle("t2d");
    checkOutput("t2.rr", 32'(bus.gnt_o), 32'(expRr));
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    cycle("t2e");

    // Owner 2 releases while RegIO busy: drain for 5 cycles, then client 3
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    cycle("t3a");
    checkOutput("t3.gnt", 32'(bus.gnt_o), 32'b0100);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1000, 4'b0100, 1'b1);
      checkOutput("t3.drain_cmd", 32'(bus.NewCommand_o), 32'(i == 0));
      cycle("t3b");
      checkOutput("t3.drain_gnt", 32'(bus.gnt_o), 32'b0100);
      checkOutput("t3.drain_off", 32'(bus.offset_o), 32'h12);
    end
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    cycle("t3c");
    checkOutput("t3.dead", 32'(bus.gnt_o), 32'd0);
    cycle("t3d");
    checkOutput("t3.next", 32'(bus.gnt_o), 32'b1000);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    cycle("t3e");

    // Watchdog: io_busy stuck high while client 2 owns
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    cycle("t4a");
    for (int i = 1; i <= TO; i++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      cycle("t4b");
      checkOutput("t4.err", 32'(bus.err_o), 32'(i == TO));
      checkOutput("t4.gnt", 32'(bus.gnt_o), (i == TO) ? 32'd0 : 32'b0100);
    end
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    cycle("t4c");
    checkOutput("t4.regrant", 32'(bus.gnt_o), 32'b0100);
    checkOutput("t4.sticky", 32'(bus.err_o), 32'd1);

    // Asynchronous reset during ownership
    RSTN = 1'b0;
    #1;
    checkOutput("t5.gnt", 32'(bus.gnt_o), 32'd0);
    checkOutput("t5.err", 32'(bus.err_o), 32'd0);
    checkOutput("t5.length", 32'(bus.length_o), 32'd1);
    modelReset();
    applyStimulus(4'b0011, 4'b0000, 1'b0);
    checkAll("t5.rst");
    @(negedge clk40m);
    RSTN = 1'b1;
    edgeOnly();
    checkOutput("t5.ptr0", 32'(bus.gnt_o), 32'(expRst));
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    cycle("t5b");

    // Randomized traffic against the reference model
    rq       = 4'd0;
    longBusy = 0;
    for (int n = 0; n < 400; n++) begin
      bus.cli_offset_i = $urandom;
      bus.cli_length_i = 4'($urandom);
      bus.cli_wr_i     = 4'($urandom);
      bus.cli_wdata_i  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      if (longBusy > 0) longBusy--;
      else if ($urandom_range(0, 49) == 0) longBusy = 20;
      bsy = (longBusy > 0) || ($urandom_range(0, 99) < 35);
      applyStimulus(rq, 4'($urandom), bsy);
      cycle("rnd");
      if (n == 250) begin
        RSTN = 1'b0;
        modelReset();
        #1;
        checkAll("rnd.rst");
        @(negedge clk40m);
        RSTN = 1'b1;
        edgeOnly();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
